approx_recursive_mult_seq: RTL

//   Sequential, parametrised recursive multiplier: WIDTH-bit operands split into 4-bit nibbles,
//   one 4x4 sub-product per cycle, shifted and accumulated into a 2*WIDTH-bit result.

---
 rtl/approx_recursive_mult_seq.sv | 129 ++++++++++++
 1 files changed

// File: rtl/approx_recursive_mult_seq.sv
// rtl/approx_recursive_mult_seq.sv - sequential nibble-recursive multiplier with per-block OR approximation
module approx_recursive_mult_seq #(
  parameter int WIDTH        = 8,
  parameter int APPROX_ORDER = 1,
  parameter int MSB_FIX      = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               mode_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int N  = WIDTH / 4;
  localparam int NN = N * N;
  localparam int KW = $clog2(NN);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r;
  logic            mode_r;
  logic [KW-1:0]   k;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   product_r;

  int              idx_i, idx_j;
  logic [3:0]      a_nib, b_nib;
  logic [7:0]      sub_exact, sub_approx, sub_prod;
  logic            approx_sel;
  logic [PW-1:0]   term;
  logic            last_k;

  // OR-approximate 4x4: each output column ORs its partial products; bit 7 is a fixed constant
  function automatic logic [7:0] approx4(input logic [3:0] x, input logic [3:0] y);
    logic [7:0] r;
    r = '0;
    for (int p = 0; p < 4; p++) begin
      for (int q = 0; q < 4; q++) begin
        r[p+q] = r[p+q] | (x[p] & y[q]);
      end
    end
    r[7] = (MSB_FIX != 0);
    return r;
  endfunction

  // select the nibble pair for step k and form its shifted sub-product
  always_comb begin
    idx_i      = int'(k) % N;
    idx_j      = int'(k) / N;
    a_nib      = a_r[4*idx_i +: 4];
    b_nib      = b_r[4*idx_j +: 4];
    sub_exact  = {4'b0000, a_nib} * {4'b0000, b_nib};
    sub_approx = approx4(a_nib, b_nib);
    approx_sel = mode_r && ((idx_i + idx_j) < APPROX_ORDER);
    sub_prod   = approx_sel ? sub_approx : sub_exact;
    term       = PW'(sub_prod) << (4 * (idx_i + idx_j));
    last_k     = (k == KW'(NN - 1));
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CALC;
      end
      CALC: begin
        if (last_k) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // operand capture, accumulation and result hold
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r       <= '0;
      b_r       <= '0;
      mode_r    <= 1'b0;
      k         <= '0;
      acc       <= '0;
      product_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r    <= a_i;
            b_r    <= b_i;
            mode_r <= mode_i;
            acc    <= '0;
            k      <= '0;
          end
        end
        CALC: begin
          acc <= acc + term;
          k   <= k + KW'(1);
          if (last_k) begin
            product_r <= acc + term;
            k         <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign product_o = product_r;

endmodule
